neuron_sample_feeder: RTL and testbench

- Training-set sequencer that sits directly upstream of the two-input perceptron datapath.
- Holds a small sample memory of (x1, x2, t) entries, loaded by the host over a write port.
- On start, streams the samples to the neuron in epochs over a valid/ready handshake and collects the per-sample yEqualt result.
- Stops when a whole epoch classifies correctly (converged) or the epoch limit is reached.

---
 rtl/neuron_pkg.sv | 24 ++
 rtl/sample_mem.sv | 31 +++
 rtl/neuron_sample_feeder.sv | 154 +++++++++++++++
 tb/tb_neuron_sample_feeder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the perceptron training path: sample field widths,
// target encodings and the sample feeder's state encoding.
package neuron_pkg;

    localparam int X_W = 7;
    localparam int T_W = 2;
    localparam int S_W = 2 * X_W + T_W;

    localparam logic [T_W-1:0] T_POS = 2'b01;
    localparam logic [T_W-1:0] T_NEG = 2'b11;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_RES  = 3'd2;
    localparam logic [2:0] ST_EPOCH_END = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef struct packed {
        logic [X_W-1:0] x1;
        logic [X_W-1:0] x2;
        logic [T_W-1:0] t;
    } sample_t;

endpackage

// File: rtl/sample_mem.sv
// Sample register file: one write port, one asynchronous read port,
// cleared to zero while the active-low reset is held.
module sample_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 16
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/neuron_sample_feeder.sv
// Training-set sequencer: streams stored (x1, x2, t) samples to the neuron in
// epochs until an error-free epoch or the epoch limit ends the run.
module neuron_sample_feeder
    import neuron_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int EPOCH_W   = 8,
    parameter int MAX_EPOCH = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wrEn,
    input  logic [ADDR_W-1:0]  wrAddr,
    input  logic [X_W-1:0]     wrX1,
    input  logic [X_W-1:0]     wrX2,
    input  logic [T_W-1:0]     wrT,
    input  logic [ADDR_W:0]    numSamples,
    input  logic               start,
    output logic               sampleValid,
    input  logic               sampleReady,
    output logic [X_W-1:0]     x1Out,
    output logic [X_W-1:0]     x2Out,
    output logic [T_W-1:0]     tOut,
    input  logic               resultValid,
    input  logic               yEqualt,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epochCount
);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_err;
    logic [ADDR_W:0]   r_num;

    logic              w_we;
    logic [ADDR_W-1:0] w_rd_addr;
    sample_t           w_wr_sample;
    sample_t           w_rd_sample;
    sample_t           w_sample;
    logic              w_last;
    logic [EPOCH_W-1:0] w_ep_next;

    assign w_we        = wrEn & ~busy;
    assign w_wr_sample = '{x1: wrX1, x2: wrX2, t: wrT};
    // Only WAIT_RES loads a non-zero slot; every other load starts an epoch at 0.
    assign w_rd_addr   = (r_state == ST_WAIT_RES) ? r_idx + 1'b1 : '0;
    // A write landing on the slot being loaded this edge must be seen by the run.
    assign w_sample    = (w_we && (wrAddr == w_rd_addr)) ? w_wr_sample : w_rd_sample;
    assign w_last      = ({1'b0, r_idx} == (r_num - 1'b1));
    assign w_ep_next   = epochCount + 1'b1;

    sample_mem #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .WIDTH (S_W)
    ) u_mem (
        .clk    (clk),
        .i_rst_n(reset),
        .i_we   (w_we),
        .i_waddr(wrAddr),
        .i_wdata(w_wr_sample),
        .i_raddr(w_rd_addr),
        .o_rdata(w_rd_sample)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_num       <= '0;
            sampleValid <= 1'b0;
            x1Out       <= '0;
            x2Out       <= '0;
            tOut        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            epochCount  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (r_state == ST_DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                    if (start && !busy) begin
                        r_num      <= numSamples;
                        r_idx      <= '0;
                        r_err      <= 1'b0;
                        epochCount <= '0;
                        done       <= 1'b0;
                        converged  <= 1'b0;
                        busy       <= 1'b1;
                        if (numSamples == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state     <= ST_ISSUE;
                            x1Out       <= w_sample.x1;
                            x2Out       <= w_sample.x2;
                            tOut        <= w_sample.t;
                            sampleValid <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (sampleReady) begin
                        sampleValid <= 1'b0;
                        r_state     <= ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (resultValid) begin
                        if (!yEqualt) begin
                            r_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= ST_EPOCH_END;
                        end else begin
                            r_idx       <= r_idx + 1'b1;
                            x1Out       <= w_sample.x1;
                            x2Out       <= w_sample.x2;
                            tOut        <= w_sample.t;
                            sampleValid <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end
                    end
                end
                ST_EPOCH_END: begin
                    epochCount <= w_ep_next;
                    if (!r_err) begin
                        converged <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (w_ep_next == EPOCH_W'(MAX_EPOCH)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx       <= '0;
                        r_err       <= 1'b0;
                        x1Out       <= w_sample.x1;
                        x2Out       <= w_sample.x2;
                        tOut        <= w_sample.t;
                        sampleValid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_sample_feeder.sv
// Scoreboard bench for neuron_sample_feeder: a run-level model predicts the
// sample stream and final status; a monitor checks every accepted sample.
module tb_neuron_sample_feeder;
    import neuron_pkg::*;

    localparam int MAXE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wrEn = 1'b0;
    logic [3:0] wrAddr = '0;
    logic [6:0] wrX1 = '0, wrX2 = '0;
    logic [1:0] wrT = '0;
    logic [4:0] numSamples = '0;
    logic       start = 1'b0;
    logic       sampleValid;
    logic       sampleReady = 1'b1;
    logic [6:0] x1Out, x2Out;
    logic [1:0] tOut;
    logic       resultValid = 1'b0;
    logic       yEqualt = 1'b0;
    logic       busy, done, converged;
    logic [7:0] epochCount;

    neuron_sample_feeder #(.DEPTH(16), .ADDR_W(4), .EPOCH_W(8), .MAX_EPOCH(MAXE)) dut (
        .clk(clk), .reset(reset), .wrEn(wrEn), .wrAddr(wrAddr), .wrX1(wrX1), .wrX2(wrX2),
        .wrT(wrT), .numSamples(numSamples), .start(start), .sampleValid(sampleValid),
        .sampleReady(sampleReady), .x1Out(x1Out), .x2Out(x2Out), .tOut(tOut),
        .resultValid(resultValid), .yEqualt(yEqualt), .busy(busy), .done(done),
        .converged(converged), .epochCount(epochCount)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mdl_mem [16];
    bit          plan_err [8][16];
    logic [15:0] exp_q [$];
    int          exp_ep;
    bit          exp_conv;
    int          n_cur = 0;
    int          resp_k = 0;
    int          fixed_delay = -1;
    int          acc_cnt = 0;
    int          hold_cnt = 0;
    bit          rand_ready = 0;
    bit          run_active = 0;
    bit          pend = 0;
    logic [15:0] pend_data;

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run-level model: epochs of the stored samples, an epoch fails if any planned error.
    function automatic void build_expect(input int n);
        bit err;
        exp_q.delete();
        exp_ep = 0;
        exp_conv = 0;
        if (n == 0) return;
        for (int e = 0; e < MAXE; e++) begin
            err = 0;
            for (int s = 0; s < n; s++) begin
                exp_q.push_back(mdl_mem[s]);
                if (plan_err[e][s]) err = 1;
            end
            exp_ep = e + 1;
            if (!err) begin
                exp_conv = 1;
                break;
            end
        end
    endfunction

    function automatic void clear_plan();
        for (int e = 0; e < 8; e++)
            for (int s = 0; s < 16; s++) plan_err[e][s] = 0;
    endfunction

    always @(posedge clk) begin
        #2;
        if (hold_cnt > 0) begin
            sampleReady = 1'b0;
            hold_cnt--;
        end else begin
            sampleReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            pend = 0;
        end else begin
            if (pend) begin
                check_eq("hold_valid", sampleValid, 1);
                check_eq("hold_data", {x1Out, x2Out, tOut}, pend_data);
            end
            pend = 0;
            if (sampleValid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", sampleValid, 0);
                end else if (sampleReady) begin
                    check_eq("sample_data", {x1Out, x2Out, tOut}, exp_q.pop_front());
                    acc_cnt++;
                end else begin
                    pend = 1;
                    pend_data = {x1Out, x2Out, tOut};
                end
            end
        end
    end

    initial begin
        int kk, e, s, d;
        forever begin
            @(negedge clk);
            while (reset && sampleValid && sampleReady) begin
                kk = resp_k;
                resp_k++;
                e = (n_cur == 0) ? 0 : (kk / n_cur) % 8;
                s = (n_cur == 0) ? 0 : kk % n_cur;
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
                repeat (1 + d) @(negedge clk);
                resultValid = 1'b1;
                yEqualt = !plan_err[e][s];
                @(negedge clk);
                resultValid = 1'b0;
            end
        end
    end

    task automatic wr(input int a, input logic [6:0] x1, input logic [6:0] x2, input logic [1:0] t);
        @(negedge clk);
        wrEn = 1'b1;
        wrAddr = 4'(a);
        wrX1 = x1;
        wrX2 = x2;
        wrT = t;
        if (!run_active) mdl_mem[a] = {x1, x2, t};
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    task automatic wr_rand(input int a);
        wr(a, 7'($urandom), 7'($urandom), ($urandom_range(0, 1) != 0) ? T_POS : T_NEG);
    endtask

    task automatic run(input int n, input bit wr0, input logic [15:0] wd);
        int cyc;
        n_cur = n;
        resp_k = 0;
        if (wr0) mdl_mem[0] = wd;
        build_expect(n);
        @(negedge clk);
        numSamples = 5'(n);
        start = 1'b1;
        if (wr0) begin
            wrEn = 1'b1;
            wrAddr = '0;
            {wrX1, wrX2, wrT} = wd;
        end
        @(negedge clk);
        start = 1'b0;
        wrEn = 1'b0;
        run_active = 1;
        cyc = 1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        run_active = 0;
        check_eq("run_done", done, 1);
        if (n == 0) check_eq("empty_done_latency", cyc, 2);
        check_eq("epochCount", epochCount, exp_ep);
        check_eq("converged", converged, exp_conv);
        check_eq("busy_after_done", busy, 0);
        check_eq("valid_after_done", sampleValid, 0);
        check_eq("samples_left", exp_q.size(), 0);
    endtask

    initial begin
        int base, cyc, n;
        for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
        clear_plan();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_valid", sampleValid, 0);
        check_eq("rst_conv", converged, 0);
        check_eq("rst_epoch", epochCount, 0);
        check_eq("rst_data", {x1Out, x2Out, tOut}, 0);

        for (int i = 0; i < 4; i++) wr_rand(i);
        run(4, 0, '0);

        plan_err[0][2] = 1;
        plan_err[1][2] = 1;
        base = acc_cnt;
        run(4, 0, '0);
        check_eq("accepts_3_epochs", acc_cnt - base, 12);

        for (int e = 0; e < 8; e++)
            for (int s = 0; s < 16; s++) plan_err[e][s] = 1;
        base = acc_cnt;
        run(4, 0, '0);
        check_eq("accepts_max_epoch", acc_cnt - base, 12);

        clear_plan();
        run(0, 0, '0);

        hold_cnt = 6;
        fork
            run(4, 0, '0);
            begin
                repeat (4) @(negedge clk);
                wr(0, 7'h55, 7'h2a, T_NEG);
            end
        join
        run(1, 0, '0);

        run(3, 1, {7'h11, 7'h22, T_POS});

        rand_ready = 1;
        for (int r = 0; r < 5; r++) begin
            n = int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) wr_rand(i);
            for (int e = 0; e < 8; e++)
                for (int s = 0; s < 16; s++) plan_err[e][s] = ($urandom_range(0, 9) < 1);
            run(n, 0, '0);
        end
        rand_ready = 0;

        clear_plan();
        plan_err[0][1] = 1;
        for (int i = 0; i < 4; i++) wr_rand(i);
        fixed_delay = 3;
        n_cur = 4;
        resp_k = 0;
        build_expect(4);
        base = acc_cnt;
        @(negedge clk);
        numSamples = 5'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (acc_cnt < base + 5 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_epoch2", acc_cnt - base, 5);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_epoch", epochCount, 0);
        check_eq("midrst_valid", sampleValid, 0);
        repeat (6) @(negedge clk);
        check_eq("late_result_busy", busy, 0);
        check_eq("late_result_valid", sampleValid, 0);
        check_eq("late_result_done", done, 0);
        fixed_delay = -1;
        clear_plan();
        run(2, 0, '0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
